multiplier_datapath: RTL and testbench

Register datapath for the shift-add multiplier, sitting directly downstream of the multiplier `sequencer` and driven by its control strobes. It holds multiplicand M, accumulator A, carry C and multiplier/low-product register Q. It performs the add and shift micro-operations commanded each clock and returns Q0 to the sequencer. When the sequencer signals completion, it captures the 2·WIDTH-bit product into an output holding register with a valid/ack handshake.

---
 rtl/mult_pkg.sv | 14 +
 rtl/result_holder.sv | 41 ++++
 rtl/multiplier_datapath.sv | 65 ++++++
 tb/tb_multiplier_datapath.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizes for the shift-add multiplier (sequencer and datapath).
package mult_pkg;

  localparam int MULT_WIDTH = 4;
  localparam int PWIDTH     = 2 * MULT_WIDTH;

  // Working register {C,A,Q}: carry, accumulator, multiplier/low product.
  typedef struct packed {
    logic                  c;
    logic [MULT_WIDTH-1:0] a;
    logic [MULT_WIDTH-1:0] q;
  } dp_reg_t;

endpackage

// File: rtl/result_holder.sv
// Captures {A,Q} on a rising ready edge and holds it under a valid/ack handshake.
module result_holder
  import mult_pkg::*;
#(
  parameter int PW = PWIDTH
) (
  input  logic          clock,
  input  logic          n_rst,
  input  logic          ready,
  input  logic          result_ack,
  input  logic [PW-1:0] prod_in,
  output logic [PW-1:0] product,
  output logic          result_valid,
  output logic          overrun
);

  logic ready_d;
  logic capture;

  assign capture = ready & ~ready_d;

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      ready_d      <= 1'b0;
      product      <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      ready_d <= ready;
      // A capture coinciding with an ack replaces the old result cleanly.
      if (capture) begin
        product      <= prod_in;
        result_valid <= 1'b1;
        if (result_valid && !result_ack) overrun <= 1'b1;
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: M, {C,A,Q} micro-ops and result capture.
// WIDTH must match mult_pkg::MULT_WIDTH, which sizes the shared register struct.
module multiplier_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clock,
  input  logic               n_rst,
  input  logic               reset,
  input  logic               add,
  input  logic               shift,
  input  logic               ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               result_ack,
  output logic               Q0,
  output logic [2*WIDTH-1:0] product,
  output logic               result_valid,
  output logic               overrun
);

  dp_reg_t          r;
  dp_reg_t          r_next;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   sum;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    sum    = {1'b0, r.a} + {1'b0, m};
    r_next = r;
    if (reset) begin
      r_next = '{c: 1'b0, a: '0, q: multiplier};
    end else begin
      if (add) {r_next.c, r_next.a} = sum;
      // Shift consumes the post-add {C,A} when both strobes are present.
      if (shift) r_next = {1'b0, r_next.c, r_next.a, r.q[WIDTH-1:1]};
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      r <= '0;
      m <= '0;
    end else begin
      r <= r_next;
      if (reset) m <= multiplicand;
    end
  end

  assign Q0 = r.q[0];

  result_holder #(.PW(2 * WIDTH)) u_result_holder (
    .clock        (clock),
    .n_rst        (n_rst),
    .ready        (ready),
    .result_ack   (result_ack),
    .prod_in      ({r.a, r.q}),
    .product      (product),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench: arithmetic reference model plus directed literal scenarios.
module tb_multiplier_datapath;
  import mult_pkg::*;

  localparam int W = MULT_WIDTH;

  logic           clock = 1'b0;
  logic           n_rst, reset, add, shift, ready, result_ack;
  logic [W-1:0]   multiplicand, multiplier;
  logic           Q0;
  logic [2*W-1:0] product;
  logic           result_valid, overrun;

  int errors = 0;
  int checks = 0;

  multiplier_datapath #(.WIDTH(W)) dut (
    .clock        (clock),
    .n_rst        (n_rst),
    .reset        (reset),
    .add          (add),
    .shift        (shift),
    .ready        (ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result_ack   (result_ack),
    .Q0           (Q0),
    .product      (product),
    .result_valid (result_valid),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {C,A,Q} is one integer; add puts M above Q, shift halves it.
  logic [2*W:0]   acc;
  logic [2*W-1:0] aq;
  logic [W-1:0]   m_mod;
  logic [2*W-1:0] prod_exp;
  bit             val_exp, ovr_exp, rd_exp;
  bit             model_ok = 1'b0;

  always @(posedge clock) begin
    aq = acc[2*W-1:0];
    if (!n_rst) begin
      acc = '0; m_mod = '0; prod_exp = '0;
      val_exp = 1'b0; ovr_exp = 1'b0; rd_exp = 1'b0;
      model_ok = 1'b1;
    end else begin
      if (ready && !rd_exp) begin
        if (val_exp && !result_ack) ovr_exp = 1'b1;
        prod_exp = aq;
        val_exp  = 1'b1;
      end else if (result_ack) begin
        val_exp = 1'b0;
      end
      rd_exp = ready;
      if (reset) begin
        m_mod = multiplicand;
        acc   = {{(W+1){1'b0}}, multiplier};
      end else begin
        if (add)   acc = {1'b0, aq} + ({{(W+1){1'b0}}, m_mod} << W);
        if (shift) acc = acc >> 1;
      end
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      check("model_q0",      {31'd0, Q0},           {31'd0, acc[0]});
      check("model_product", {24'd0, product},      {24'd0, prod_exp});
      check("model_valid",   {31'd0, result_valid}, {31'd0, val_exp});
      check("model_overrun", {31'd0, overrun},      {31'd0, ovr_exp});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic q0_log [W];

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_load(input logic [W-1:0] mc, input logic [W-1:0] mp);
    reset = 1'b1; multiplicand = mc; multiplier = mp;
    tick();
    reset = 1'b0;
  endtask

  // Sequencer behaviour: add when Q0 is set, then shift.
  task automatic do_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      add = Q0;
      tick();
      add = 1'b0; shift = 1'b1;
      tick();
      shift = 1'b0;
      q0_log[i] = Q0;
    end
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic ack_once();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  initial begin
    logic [W-1:0] mc, mp;
    n_rst = 1'b0; reset = 1'b0; add = 1'b0; shift = 1'b0; ready = 1'b0;
    result_ack = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) tick();
    check("rst_q0", {31'd0, Q0}, 32'd0);
    check("rst_product", {24'd0, product}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    n_rst = 1'b1;
    tick();

    // 13 x 11
    do_load(4'd13, 4'd11); do_pairs(W); pulse_ready();
    check("m13x11_product", {24'd0, product}, 32'h8F);
    check("m13x11_valid", {31'd0, result_valid}, 32'd1);
    check("m13x11_overrun", {31'd0, overrun}, 32'd0);
    ack_once();

    // 15 x 15 exercises the carry
    do_load(4'd15, 4'd15); do_pairs(W); pulse_ready();
    check("m15x15_product", {24'd0, product}, 32'hE1);
    ack_once();

    // 0 x 9: Q0 walks through the multiplier bits
    do_load(4'd0, 4'd9);
    check("m0x9_q0_load", {31'd0, Q0}, 32'd1);
    do_pairs(W);
    check("m0x9_q0_s1", {31'd0, q0_log[0]}, 32'd0);
    check("m0x9_q0_s2", {31'd0, q0_log[1]}, 32'd0);
    check("m0x9_q0_s3", {31'd0, q0_log[2]}, 32'd1);
    pulse_ready();
    check("m0x9_product", {24'd0, product}, 32'h00);
    ack_once();

    // Capture and ack in the same cycle
    do_load(4'd2, 4'd3); do_pairs(W); pulse_ready();
    do_load(4'd4, 4'd4); do_pairs(W);
    ready = 1'b1; result_ack = 1'b1;
    tick();
    ready = 1'b0; result_ack = 1'b0;
    check("same_cycle_valid", {31'd0, result_valid}, 32'd1);
    check("same_cycle_product", {24'd0, product}, 32'h10);
    check("same_cycle_overrun", {31'd0, overrun}, 32'd0);
    ack_once();

    // ready held high: one capture only
    do_load(4'd5, 4'd5); do_pairs(W);
    ready = 1'b1;
    tick();
    check("held_first_valid", {31'd0, result_valid}, 32'd1);
    result_ack = 1'b1;
    repeat (4) tick();
    check("held_valid_after_ack", {31'd0, result_valid}, 32'd0);
    check("held_product", {24'd0, product}, 32'h19);
    ready = 1'b0; result_ack = 1'b0;
    tick();

    // Overrun: second result lands on an unacknowledged one
    do_load(4'd6, 4'd7); do_pairs(W); pulse_ready();
    check("ovr_first_product", {24'd0, product}, 32'd42);
    do_load(4'd3, 4'd5); do_pairs(W); pulse_ready();
    check("ovr_product", {24'd0, product}, 32'h0F);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    ack_once();
    check("ovr_valid_after_ack", {31'd0, result_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // add+shift together with A=0xF, M=1, Q=3
    do_load(4'd1, 4'd3);
    add = 1'b1;
    repeat (15) tick();
    shift = 1'b1;
    tick();
    add = 1'b0; shift = 1'b0;
    check("addshift_q0", {31'd0, Q0}, 32'd1);
    pulse_ready();
    check("addshift_product", {24'd0, product}, 32'h81);

    // n_rst mid-multiply
    do_load(4'd13, 4'd11); do_pairs(2);
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("abort_q0", {31'd0, Q0}, 32'd0);
    check("abort_product", {24'd0, product}, 32'd0);
    check("abort_valid", {31'd0, result_valid}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    tick();

    // Random full multiplies against plain arithmetic
    for (int k = 0; k < 40; k++) begin
      mc = W'($urandom_range(0, (1 << W) - 1));
      mp = W'($urandom_range(0, (1 << W) - 1));
      do_load(mc, mp); do_pairs(W); pulse_ready();
      check("rand_mult", {24'd0, product}, int'(mc) * int'(mp));
      ack_once();
    end

    // Random strobes, compared cycle by cycle with the model
    for (int k = 0; k < 1500; k++) begin
      n_rst        = ($urandom_range(0, 99) != 0);
      reset        = ($urandom_range(0, 9) == 0);
      add          = 1'($urandom);
      shift        = 1'($urandom);
      ready        = ($urandom_range(0, 3) == 0);
      result_ack   = ($urandom_range(0, 2) == 0);
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      tick();
    end
    n_rst = 1'b1; reset = 1'b0; add = 1'b0; shift = 1'b0; ready = 1'b0; result_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
